// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit.
// Mode codes, FSM states and the effective-count helper.
package shift_pkg;

  localparam logic [2:0] FUN_LSR = 3'b000;
  localparam logic [2:0] FUN_LSL = 3'b001;
  localparam logic [2:0] FUN_ASR = 3'b010;
  localparam logic [2:0] FUN_ROR = 3'b011;
  localparam logic [2:0] FUN_ROL = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_reserved(
    input logic [2:0] mode
  );
    is_reserved = (mode > FUN_ROL);
  endfunction

  // Shifts saturate at the width; rotates wrap.
  function automatic int unsigned eff_amt(
    input logic [2:0]  mode,
    input int unsigned shamt,
    input int unsigned width
  );
    eff_amt = 0;
    unique case (mode)
      FUN_LSR, FUN_LSL, FUN_ASR:
        eff_amt = (shamt > width) ? width : shamt;
      FUN_ROR, FUN_ROL:
        eff_amt = shamt % width;
      default:
        eff_amt = 0;
    endcase
  endfunction

endpackage

// File: rtl/iter_shift_step.sv
// One-position shift/rotate step.
// Reserved modes produce zero with no carry.
module iter_shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] w_next,
  output logic             carry
);

  always_comb begin
    w_next = '0;
    carry  = 1'b0;
    unique case (mode)
      FUN_LSR: begin
        carry  = w[0];
        w_next = {1'b0, w[WIDTH-1:1]};
      end
      FUN_LSL: begin
        carry  = w[WIDTH-1];
        w_next = {w[WIDTH-2:0], 1'b0};
      end
      FUN_ASR: begin
        carry  = w[0];
        w_next = {w[WIDTH-1], w[WIDTH-1:1]};
      end
      FUN_ROR: begin
        carry  = w[0];
        w_next = {w[0], w[WIDTH-1:1]};
      end
      FUN_ROL: begin
        carry  = w[WIDTH-1];
        w_next = {w[WIDTH-2:0], w[WIDTH-1]};
      end
      default: begin
        carry  = 1'b0;
        w_next = '0;
      end
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-position shift/rotate unit, one bit per clock.
// Start/busy/done handshake with synchronous abort.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Shift_Enable,
  input  logic               Shift_Clear,
  input  logic [2:0]         ALU_FUN,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] SHAMT,
  output logic               Busy,
  output logic [WIDTH-1:0]   Shift_OUT,
  output logic               Carry_OUT,
  output logic               Shift_Flag
);

  localparam int CLG  = $clog2(WIDTH + 1);
  localparam int CNT_W = (SHAMT_W > CLG) ? SHAMT_W : CLG;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] w_next;
  logic             carry;
  logic             c_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       mode;
  logic             start;
  logic             finish;
  logic             step;

  iter_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode   (mode),
    .w      (work),
    .w_next (w_next),
    .carry  (c_next)
  );

  always_comb begin
    state_n = state;
    start   = 1'b0;
    finish  = 1'b0;
    step    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (Shift_Enable && !Shift_Clear) begin
          start   = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (Shift_Clear) begin
          state_n = ST_IDLE;
        end else if (cnt == '0) begin
          finish  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      work       <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      mode       <= FUN_LSR;
      Shift_OUT  <= '0;
      Carry_OUT  <= 1'b0;
      Shift_Flag <= 1'b0;
    end else begin
      state      <= state_n;
      Shift_Flag <= finish;
      if (start) begin
        // Reserved modes start from zero so they complete as a zero result.
        work  <= is_reserved(ALU_FUN) ? '0 : A;
        mode  <= ALU_FUN;
        carry <= 1'b0;
        cnt   <= CNT_W'(eff_amt(ALU_FUN, 32'(SHAMT), WIDTH));
      end else if (step) begin
        work  <= w_next;
        carry <= c_next;
        cnt   <= cnt - CNT_W'(1);
      end
      if (finish) begin
        Shift_OUT <= work;
        Carry_OUT <= carry;
      end
    end
  end

  assign Busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit (WIDTH=8).
// Directed table, random ops vs. reference model, handshake corners.
module tb_iter_shift_unit;
  import shift_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Shift_Enable;
  logic       Shift_Clear;
  logic [2:0] ALU_FUN;
  logic [7:0] A;
  logic [3:0] SHAMT;
  logic       Busy;
  logic [7:0] Shift_OUT;
  logic       Carry_OUT;
  logic       Shift_Flag;

  int n_cmp = 0;
  int n_bad = 0;

  iter_shift_unit #(
    .WIDTH   (8),
    .SHAMT_W (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Shift_Enable (Shift_Enable),
    .Shift_Clear  (Shift_Clear),
    .ALU_FUN      (ALU_FUN),
    .A            (A),
    .SHAMT        (SHAMT),
    .Busy         (Busy),
    .Shift_OUT    (Shift_OUT),
    .Carry_OUT    (Carry_OUT),
    .Shift_Flag   (Shift_Flag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] fun;
    logic [7:0] a;
    logic [3:0] sh;
    logic [7:0] res;
    logic       c;
    int         lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Whole-operation reference: result from plain arithmetic on the operand.
  function automatic void model(input logic [2:0] f, input logic [7:0] a,
                                input logic [3:0] s, output logic [7:0] r,
                                output logic c, output int lat);
    int n;
    logic [15:0] t;
    logic [15:0] d;
    d = {a, a};
    n = 0;
    r = '0;
    c = 1'b0;
    case (f)
      FUN_LSR: begin
        n = (s > 8) ? 8 : int'(s);
        t = {8'h00, a} >> n;
        r = t[7:0];
        c = (n == 0) ? 1'b0 : a[n-1];
      end
      FUN_LSL: begin
        n = (s > 8) ? 8 : int'(s);
        t = {8'h00, a} << n;
        r = t[7:0];
        c = (n == 0) ? 1'b0 : a[8-n];
      end
      FUN_ASR: begin
        n = (s > 8) ? 8 : int'(s);
        t = {{8{a[7]}}, a} >> n;
        r = t[7:0];
        c = (n == 0) ? 1'b0 : a[n-1];
      end
      FUN_ROR: begin
        n = int'(s) % 8;
        t = d >> n;
        r = t[7:0];
        c = (n == 0) ? 1'b0 : r[7];
      end
      FUN_ROL: begin
        n = int'(s) % 8;
        t = d << n;
        r = t[15:8];
        c = (n == 0) ? 1'b0 : r[0];
      end
      default: begin
        n = 0;
        r = '0;
        c = 1'b0;
      end
    endcase
    lat = n + 1;
  endfunction

  // Wait (bounded) for the done pulse; inputs are scrambled while busy.
  task automatic wait_flag(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      A       = 8'($urandom);
      SHAMT   = 4'($urandom);
      ALU_FUN = 3'($urandom);
      @(posedge CLK);
      #1;
      lat++;
      if (Shift_Flag) break;
    end
    chk("flag_seen", 32'(Shift_Flag), 1);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [7:0] a,
                        input logic [3:0] s, output logic [7:0] r,
                        output logic c, output int lat);
    @(negedge CLK);
    ALU_FUN      = f;
    A            = a;
    SHAMT        = s;
    Shift_Enable = 1'b1;
    @(posedge CLK);
    #1;
    Shift_Enable = 1'b0;
    chk("busy_after_start", 32'(Busy), 1);
    wait_flag(lat);
    r = Shift_OUT;
    c = Carry_OUT;
  endtask

  vec_t       tbl[$];
  logic [7:0] r;
  logic [7:0] er;
  logic       c;
  logic       ec;
  int         lat;
  int         elat;
  int         flags;

  initial begin
    RST          = 1'b1;
    Shift_Enable = 1'b0;
    Shift_Clear  = 1'b0;
    ALU_FUN      = '0;
    A            = '0;
    SHAMT        = '0;

    tbl.push_back('{FUN_LSL, 8'h81, 4'd3,  8'h08, 1'b0, 4});
    tbl.push_back('{FUN_ASR, 8'h90, 4'd9,  8'hFF, 1'b1, 9});
    tbl.push_back('{FUN_LSR, 8'h90, 4'd9,  8'h00, 1'b1, 9});
    tbl.push_back('{FUN_ROR, 8'h01, 4'd9,  8'h80, 1'b1, 2});
    tbl.push_back('{FUN_ROR, 8'h01, 4'd8,  8'h01, 1'b0, 1});
    tbl.push_back('{FUN_ROL, 8'h80, 4'd1,  8'h01, 1'b1, 2});
    tbl.push_back('{FUN_ASR, 8'h7F, 4'd2,  8'h1F, 1'b1, 3});
    tbl.push_back('{FUN_LSR, 8'hF0, 4'd5,  8'h07, 1'b1, 6});
    tbl.push_back('{FUN_ROL, 8'h81, 4'd15, 8'hC0, 1'b0, 8});
    tbl.push_back('{FUN_LSL, 8'h3C, 4'd0,  8'h3C, 1'b0, 1});
    tbl.push_back('{3'b111,  8'h5A, 4'd3,  8'h00, 1'b0, 1});
    tbl.push_back('{3'b101,  8'hFF, 4'd7,  8'h00, 1'b0, 1});

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_out", 32'(Shift_OUT), 0);
    chk("rst_carry", 32'(Carry_OUT), 0);
    chk("rst_flag", 32'(Shift_Flag), 0);
    @(negedge CLK);
    RST = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].fun, tbl[i].a, tbl[i].sh, r, c, lat);
      chk($sformatf("tbl%0d_res", i), 32'(r), 32'(tbl[i].res));
      chk($sformatf("tbl%0d_carry", i), 32'(c), 32'(tbl[i].c));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      @(posedge CLK);
      #1;
      chk($sformatf("tbl%0d_pulse", i), 32'(Shift_Flag), 0);
      chk($sformatf("tbl%0d_hold", i), 32'(Shift_OUT), 32'(tbl[i].res));
    end

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [7:0] a;
      logic [3:0] s;
      f = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      s = 4'($urandom);
      model(f, a, s, er, ec, elat);
      run_op(f, a, s, r, c, lat);
      chk($sformatf("rnd%0d_res f=%0d a=%0h s=%0d", i, f, a, s),
          32'(r), 32'(er));
      chk($sformatf("rnd%0d_carry", i), 32'(c), 32'(ec));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
    end

    // Abort mid-shift, with an ignored start while busy.
    run_op(FUN_LSL, 8'h01, 4'd2, r, c, lat);
    chk("pre_clear_res", 32'(r), 32'h04);
    @(negedge CLK);
    ALU_FUN      = FUN_LSR;
    A            = 8'hF0;
    SHAMT        = 4'd5;
    Shift_Enable = 1'b1;
    @(posedge CLK);
    #1;
    Shift_Enable = 1'b0;
    @(posedge CLK);
    #1;
    Shift_Enable = 1'b1;
    ALU_FUN      = FUN_ROL;
    A            = 8'hFF;
    @(posedge CLK);
    #1;
    Shift_Enable = 1'b0;
    Shift_Clear  = 1'b1;
    chk("clear_busy_before", 32'(Busy), 1);
    @(posedge CLK);
    #1;
    Shift_Clear = 1'b0;
    chk("clear_busy", 32'(Busy), 0);
    chk("clear_flag", 32'(Shift_Flag), 0);
    chk("clear_out_kept", 32'(Shift_OUT), 32'h04);
    chk("clear_carry_kept", 32'(Carry_OUT), 0);
    flags = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK);
      #1;
      if (Shift_Flag || Busy) flags++;
    end
    chk("clear_no_late_flag", 32'(flags), 0);

    // Clear dominates a start in IDLE.
    @(negedge CLK);
    Shift_Enable = 1'b1;
    Shift_Clear  = 1'b1;
    ALU_FUN      = FUN_LSL;
    SHAMT        = 4'd3;
    @(posedge CLK);
    #1;
    Shift_Enable = 1'b0;
    Shift_Clear  = 1'b0;
    chk("idle_clear_nostart", 32'(Busy), 0);

    // Back-to-back: new start in the done cycle.
    @(negedge CLK);
    ALU_FUN      = FUN_ROL;
    A            = 8'h80;
    SHAMT        = 4'd1;
    Shift_Enable = 1'b1;
    @(posedge CLK);
    #1;
    Shift_Enable = 1'b0;
    wait_flag(lat);
    chk("b2b_first_res", 32'(Shift_OUT), 32'h01);
    chk("b2b_first_carry", 32'(Carry_OUT), 1);
    ALU_FUN      = FUN_LSL;
    A            = 8'h01;
    SHAMT        = 4'd1;
    Shift_Enable = 1'b1;
    @(posedge CLK);
    #1;
    Shift_Enable = 1'b0;
    chk("b2b_accepted", 32'(Busy), 1);
    chk("b2b_flag_gap", 32'(Shift_Flag), 0);
    wait_flag(lat);
    chk("b2b_second_res", 32'(Shift_OUT), 32'h02);
    chk("b2b_second_carry", 32'(Carry_OUT), 0);
    chk("b2b_second_lat", 32'(lat), 2);

    // Asynchronous reset in the middle of a shift.
    @(negedge CLK);
    ALU_FUN      = FUN_LSL;
    A            = 8'hFF;
    SHAMT        = 4'd8;
    Shift_Enable = 1'b1;
    @(posedge CLK);
    #1;
    Shift_Enable = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("arst_busy", 32'(Busy), 0);
    chk("arst_out", 32'(Shift_OUT), 0);
    chk("arst_carry", 32'(Carry_OUT), 0);
    chk("arst_flag", 32'(Shift_Flag), 0);
    @(negedge CLK);
    RST = 1'b0;

    run_op(3'b111, 8'hA5, 4'd9, r, c, lat);
    chk("resv_res", 32'(r), 0);
    chk("resv_lat", 32'(lat), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
